// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer and its attached shift register.
//   sr_ctrl_e   : shift_register control encoding (hold, shift right, shift left, load)
//   seq_state_e : sequencer FSM states
//   shift_code  : maps a direction bit to the matching shift control code
package shift_pkg;

    typedef enum logic [1:0] {
        CtrlHold = 2'd0,
        CtrlShr  = 2'd1,
        CtrlShl  = 2'd2,
        CtrlLoad = 2'd3
    } sr_ctrl_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCollect,
        StDone
    } seq_state_e;

    // dir: 0 = right shift, 1 = left shift
    function automatic sr_ctrl_e shift_code(input logic dir);
        return dir ? CtrlShl : CtrlShr;
    endfunction

endpackage

// File: rtl/shift_register.sv
// N-bit shift register driven by shift_sequencer.
//   clk, reset : clock, asynchronous active-high reset (clears q_reg)
//   ctrl       : 0 hold, 1 shift right, 2 shift left, 3 parallel load of data
//   data       : load value; data[N-1] is the serial fill bit for both shift directions
//   q_reg      : register contents
module shift_register
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] data,
    output logic [N-1:0] q_reg
);

    logic [N-1:0] q_d;
    logic [N-1:0] q_q;

    always_comb begin
        q_d = q_q;
        case (sr_ctrl_e'(ctrl))
            CtrlHold: q_d = q_q;
            // Right shift enters at the MSB, left shift enters at the LSB; the
            // sequencer always presents the serial bit on data[N-1].
            CtrlShr:  q_d = {data[N-1], q_q[N-1:1]};
            CtrlShl:  q_d = {q_q[N-2:0], data[N-1]};
            CtrlLoad: q_d = data;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_reg = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Frame sequencer for an external N-bit shift_register.
// P2S: accepts a parallel word, loads it into the register, then streams it out
//      bit by bit with ser_valid/ser_ready flow control.
// S2P: shifts N qualified serial bits into the register, then pulses out_valid
//      with the assembled word.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   mode, dir               : frame type and shift direction, sampled in IDLE only
//   in_valid/in_ready/in_data : parallel word handshake (P2S)
//   ser_in, ser_in_valid    : serial input (S2P)
//   ser_ready/ser_out/ser_valid : serial output handshake (P2S)
//   out_valid, out_data     : completed S2P word, one-cycle pulse
//   sr_ctrl, sr_data, sr_q  : shift_register control, data and current contents
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode,
    input  logic         dir,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         ser_in,
    input  logic         ser_in_valid,
    input  logic         ser_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_data,
    input  logic [N-1:0] sr_q
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    seq_state_e    state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic          dir_d, dir_q;
    logic [N-1:0]  word_d, word_q;

    // Mode needs no latch: it is fully encoded by which frame state was entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        word_d    = word_q;
        in_ready  = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        sr_ctrl   = CtrlHold;
        sr_data   = '0;

        case (state_q)
            StIdle: begin
                in_ready = ~mode;
                if (mode) begin
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = StCollect;
                end else if (in_valid) begin
                    dir_d   = dir;
                    word_d  = in_data;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                sr_ctrl = CtrlLoad;
                sr_data = word_q;
                cnt_d   = '0;
                state_d = StShift;
            end

            StShift: begin
                // sr_data stays zero so the register fills with zeros as it drains.
                ser_valid = 1'b1;
                ser_out   = dir_q ? sr_q[N-1] : sr_q[0];
                if (ser_ready) begin
                    sr_ctrl = shift_code(dir_q);
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StCollect: begin
                sr_data[N-1] = ser_in;
                if (ser_in_valid) begin
                    sr_ctrl = shift_code(dir_q);
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StDone: begin
                out_valid = 1'b1;
                out_data  = sr_q;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a shift_register attached (N = 8).
module tb_shift_sequencer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode, dir, in_valid, in_ready;
    logic [N-1:0] in_data;
    logic         ser_in, ser_in_valid, ser_ready, ser_out, ser_valid;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic [1:0]   sr_ctrl;
    logic [N-1:0] sr_data, sr_q;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.N(N)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .dir          (dir),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ser_in       (ser_in),
        .ser_in_valid (ser_in_valid),
        .ser_ready    (ser_ready),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .sr_ctrl      (sr_ctrl),
        .sr_data      (sr_data),
        .sr_q         (sr_q)
    );

    shift_register #(.N(N)) u_sr (
        .clk   (clk),
        .reset (reset),
        .ctrl  (sr_ctrl),
        .data  (sr_data),
        .q_reg (sr_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One P2S frame. Entered and left at edge+1 or later of an IDLE cycle.
    // stall_at/stall_len force ser_ready low while that bit index is presented;
    // abort_after >= 0 asserts reset once that many bits have been accepted.
    task automatic run_p2s(input logic [N-1:0] w, input logic d, input bit rnd_ready,
                           input int stall_at, input int stall_len, input int abort_after);
        logic       exp_bits [N];
        logic [1:0] code;
        int         idx, stalled, budget;
        for (int i = 0; i < N; i++) exp_bits[i] = d ? w[N-1-i] : w[i];
        code = d ? 2'd2 : 2'd1;

        mode = 1'b0; dir = d; in_valid = 1'b1; in_data = w; ser_ready = 1'b0;
        ser_in_valid = 1'b0;
        #1;
        check_eq("p2s_idle_in_ready", in_ready, 1);
        check_eq("p2s_idle_ctrl", sr_ctrl, 0);
        step();
        // LOAD cycle: disturb the frame inputs, they must be ignored.
        in_valid = 1'($urandom); in_data = N'($urandom); dir = ~d; mode = 1'($urandom);
        #1;
        check_eq("p2s_load_ctrl", sr_ctrl, 3);
        check_eq("p2s_load_data", sr_data, w);
        check_eq("p2s_load_ser_valid", ser_valid, 0);
        check_eq("p2s_load_in_ready", in_ready, 0);
        step();
        idx = 0; stalled = 0; budget = 0;
        while (idx < N && budget < 400) begin
            if (idx < N - 2) begin
                mode = 1'($urandom); dir = 1'($urandom); in_valid = 1'($urandom);
            end else begin
                mode = 1'b0; in_valid = 1'b0;
            end
            if (idx == stall_at && stalled < stall_len) begin
                ser_ready = 1'b0;
                stalled++;
            end else begin
                ser_ready = rnd_ready ? 1'($urandom) : 1'b1;
            end
            #1;
            check_eq("p2s_ser_valid", ser_valid, 1);
            check_eq("p2s_ser_out", ser_out, exp_bits[idx]);
            check_eq("p2s_busy_in_ready", in_ready, 0);
            check_eq("p2s_ctrl", sr_ctrl, ser_ready ? code : 2'd0);
            check_eq("p2s_zero_fill", sr_data, 0);
            if (ser_ready) idx++;
            budget++;
            if (abort_after >= 0 && idx == abort_after) begin
                step();
                reset = 1'b1; ser_ready = 1'b1; mode = 1'b0; in_valid = 1'b0;
                #1;
                check_eq("rst_ser_valid", ser_valid, 0);
                check_eq("rst_ser_out", ser_out, 0);
                check_eq("rst_ctrl", sr_ctrl, 0);
                check_eq("rst_data", sr_data, 0);
                check_eq("rst_out_valid", out_valid, 0);
                step();
                step();
                reset = 1'b0;
                #1;
                check_eq("rst_rel_ser_valid", ser_valid, 0);
                check_eq("rst_rel_in_ready", in_ready, 1);
                ser_ready = 1'b0;
                return;
            end
            step();
        end
        if (idx < N) check_eq("p2s_timeout", 1, 0);
        ser_ready = 1'b0; mode = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("p2s_end_ser_valid", ser_valid, 0);
        check_eq("p2s_end_in_ready", in_ready, 1);
        check_eq("p2s_end_ser_out", ser_out, 0);
    endtask

    // One S2P frame; bits[i] is the i-th serial bit delivered.
    task automatic run_s2p(input logic [N-1:0] bits, input logic d, input bit gaps);
        logic [N-1:0] exp_word;
        logic [1:0]   code;
        int           idx, budget;
        for (int i = 0; i < N; i++) begin
            if (d) exp_word[N-1-i] = bits[i];
            else   exp_word[i]     = bits[i];
        end
        code = d ? 2'd2 : 2'd1;

        mode = 1'b1; dir = d; in_valid = 1'($urandom); ser_ready = 1'b0; ser_in_valid = 1'b0;
        #1;
        check_eq("s2p_idle_in_ready", in_ready, 0);
        check_eq("s2p_idle_ctrl", sr_ctrl, 0);
        step();
        idx = 0; budget = 0;
        while (idx < N && budget < 400) begin
            if (idx < N - 1) begin
                mode = 1'($urandom); dir = 1'($urandom); in_valid = 1'($urandom);
            end else begin
                mode = 1'b0; in_valid = 1'b0;
            end
            ser_in_valid = gaps ? 1'($urandom) : 1'b1;
            ser_in       = ser_in_valid ? bits[idx] : 1'($urandom);
            #1;
            check_eq("s2p_ctrl", sr_ctrl, ser_in_valid ? code : 2'd0);
            check_eq("s2p_sr_data", sr_data, {ser_in, {(N-1){1'b0}}});
            check_eq("s2p_out_valid_low", out_valid, 0);
            check_eq("s2p_in_ready", in_ready, 0);
            if (ser_in_valid) idx++;
            budget++;
            step();
        end
        if (idx < N) check_eq("s2p_timeout", 1, 0);
        ser_in_valid = 1'b0; mode = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("s2p_done_out_valid", out_valid, 1);
        check_eq("s2p_done_word", out_data, exp_word);
        check_eq("s2p_done_ctrl", sr_ctrl, 0);
        step();
        #1;
        check_eq("s2p_pulse_end", out_valid, 0);
        check_eq("s2p_out_data_zero", out_data, 0);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; dir = 1'b0; in_valid = 1'b0; in_data = '0;
        ser_in = 1'b0; ser_in_valid = 1'b0; ser_ready = 1'b0;
        step();
        step();
        #1;
        check_eq("reset_ser_valid", ser_valid, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_ctrl", sr_ctrl, 0);
        check_eq("reset_data", sr_data, 0);
        check_eq("reset_in_ready", in_ready, 1);
        reset = 1'b0;
        step();

        run_p2s(8'hC4, 1'b0, 1'b0, -1, 0, -1);   // right: 0,0,1,0,0,0,1,1
        run_p2s(8'hC4, 1'b1, 1'b0, 2, 3, -1);    // left with bit 2 held 3 cycles
        run_s2p(8'b0000_1101, 1'b0, 1'b0);        // right -> 0x0D
        run_s2p(8'b0000_1101, 1'b1, 1'b0);        // left  -> 0xB0
        run_s2p(8'b0000_1101, 1'b0, 1'b1);        // with ser_in_valid gaps
        run_p2s(8'hC4, 1'b0, 1'b0, -1, 0, 4);     // reset after 4th bit
        run_p2s(8'h5A, 1'b1, 1'b1, -1, 0, -1);    // frame after the abort

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                run_p2s(N'($urandom), 1'($urandom), 1'b1, -1, 0, -1);
            end else begin
                run_s2p(N'($urandom), 1'($urandom), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
